mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Sequential arbiter and sequencer that shares the single data-memory port (address, read/write strobes, MemOp, write data and read data) between the instruction-fetch unit (IFU) and the load/store unit (LSU). It accepts one request at a time over a valid/ready handshake and drives the memory strobes for a fixed number of cycles. It returns a one-cycle response to the requester that owns the transaction and rejects misaligned LSU accesses before they reach memory. It sits between the IFU/LSU and the DPI-backed data-memory block, replacing their direct connections.

## Interface
- LATENCY, 1, cycles the memory strobes are held before mem_rdata is sampled (legal 1..15)
- AW, 32, address width
- DW, 32, data width
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- ifu_req_valid  in  1  IFU requests a word fetch
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_addr  in  AW  fetch address
- ifu_resp_valid  out  1  fetch data valid (one cycle)
- ifu_rdata  out  DW  fetched word
- lsu_req_valid  in  1  LSU requests an access
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_addr  in  AW  byte address
- lsu_wen  in  1  1 = store, 0 = load
- lsu_memop  in  3  MemOp encoding (000/001/010/100/101)
- lsu_wdata  in  DW  store data, low bytes significant
- lsu_resp_valid  out  1  load data / store ack valid (one cycle)
- lsu_resp_err  out  1  access rejected as misaligned, qualified by lsu_resp_valid
- lsu_rdata  out  DW  load result (0 for stores and errors)
- mem_addr  out  AW  latched address to memory
- mem_rd  out  1  memory read strobe
- mem_wr  out  1  memory write strobe
- mem_op  out  3  latched MemOp
- mem_wdata  out  DW  latched store data
- mem_rdata  in  DW  memory read result, already extended per mem_op

## Operation
- States: IDLE, BUSY, RESP.
- IDLE: select a winner among valid requesters and assert only that requester's req_ready (combinational from valid and state). On that clock edge, latch addr, op, wen and wdata plus an owner bit, load the counter with LATENCY-1, and go to BUSY.
- IFU requests are always latched with op 010 and wen 0.
- Misalignment check at accept: 001/101 with addr[1:0]==11, or 010 with addr[1:0]!=00. On a misaligned request go straight to RESP with the error flag set; mem_rd/mem_wr are never asserted.
- BUSY: mem_addr, mem_op and mem_wdata are driven from the latches.
  - mem_rd = !wen for every BUSY cycle.
  - mem_wr = wen in the first BUSY cycle only, so exactly one write per store.
  - The counter decrements each cycle. When it reaches 0, capture mem_rdata (loads) or 0 (stores) into the response register and go to RESP.
- RESP: the owner's resp_valid = 1 for one cycle, with rdata/err from the response register. The other requester's resp outputs stay 0. Next state is IDLE.
- Responses carry no backpressure; requesters must accept resp_valid unconditionally.
- Outside BUSY, mem_rd and mem_wr are 0. mem_addr, mem_op and mem_wdata keep their last latched value.
- Arbitration with MEM_ARB_RR_EN undefined: LSU has fixed priority. The IFU is granted only when lsu_req_valid=0.

## Timing
- Reset (async assert, sync release): state IDLE; all req_ready, resp_valid, resp_err, mem_rd and mem_wr are 0; all rdata, mem_addr, mem_wdata and mem_op are 0; counter 0; RR pointer = LSU.
- Reset asserted mid-transaction abandons it with no response, no further strobes, and no retried write.
- Cycle 0: accept. Cycles 1..LATENCY: BUSY. Cycle LATENCY+1: resp_valid. Cycle LATENCY+2: IDLE, earliest next accept.
- Throughput: one transaction per LATENCY+2 cycles.
- Misaligned: accept at cycle 0, resp_valid with err=1 at cycle 1, next accept at cycle 2.
- Requests presented while BUSY or RESP see ready=0 and must hold their valid and payload stable until accepted.
- mem_rdata is sampled only on the final BUSY cycle.

## Configuration
- MEM_ARB_RR_EN defined: round-robin arbitration. A 1-bit pointer records the last granted requester, and a simultaneous request goes to the other one. The pointer resets to LSU, so the first tie grants the IFU. A lone request is granted regardless of the pointer. The pointer updates on every accept, including misaligned accepts.
- MEM_ARB_RR_EN undefined: fixed LSU priority; the pointer register is not built.

## Structure
- Shared package: MemOp constants (MEMOP_B=000, MEMOP_H=001, MEMOP_W=010, MEMOP_BU=100, MEMOP_HU=101), the state enum, and the owner encoding (OWNER_IFU=0, OWNER_LSU=1).
- One sub-module, mem_arb_pick: combinational winner selection (two valids plus pointer gives a grant vector). It contains the RR logic under MEM_ARB_RR_EN. State machine, latches, counter and alignment check stay in the top module.

## Test plan
- LATENCY=1, IFU fetch of addr 0x8000_0000 with mem returning 0x0000_0413: ready at cycle 0, mem_rd=1 in cycle 1 only, then ifu_resp_valid=1 with rdata 0x0000_0413 in cycle 2.
- LATENCY=3, LSU store of wdata 0x1234_5678, op 000, addr 0x8000_0102: mem_wr=1 only in cycle 1 with mem_addr 0x8000_0102 and mem_op 000; lsu_resp_valid=1, err=0, rdata 0 in cycle 4.
- Both valid every cycle, LATENCY=1: without the macro every grant goes to LSU; with MEM_ARB_RR_EN grants alternate IFU, LSU, IFU, … with accepts every 3 cycles.
- LSU op 010 at 0x8000_0002 and op 001 at 0x8000_0003: resp_valid with err=1 one cycle after accept, mem_rd and mem_wr stay 0. Op 001 at 0x8000_0002 proceeds normally.
- rst_n pulled low in the second BUSY cycle of a LATENCY=4 load: all outputs 0 immediately, no resp_valid after release, and a new IFU request is accepted in the first cycle after release.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared MemOp codes, owner encoding and FSM states for the memory-port arbiter
package mem_port_arbiter_pkg;
  localparam logic [2:0] MEMOP_B  = 3'b000;
  localparam logic [2:0] MEMOP_H  = 3'b001;
  localparam logic [2:0] MEMOP_W  = 3'b010;
  localparam logic [2:0] MEMOP_BU = 3'b100;
  localparam logic [2:0] MEMOP_HU = 3'b101;
  localparam logic OWNER_IFU = 1'b0;
  localparam logic OWNER_LSU = 1'b1;
  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RESP} state_t;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: IFU/LSU request-response channels plus the shared data-memory port
//   ifu_*: fetch request (valid/ready/addr) and one-cycle response (valid/rdata)
//   lsu_*: load/store request (valid/ready/addr/wen/memop/wdata) and response (valid/err/rdata)
//   mem_*: latched address/op/wdata, read/write strobes, read data back from memory
//   modport master = requester/memory side, slave = arbiter
interface mem_port_arbiter_if #(parameter int AW = 32, parameter int DW = 32);
  logic          ifu_req_valid;
  logic          ifu_req_ready;
  logic [AW-1:0] ifu_addr;
  logic          ifu_resp_valid;
  logic [DW-1:0] ifu_rdata;
  logic          lsu_req_valid;
  logic          lsu_req_ready;
  logic [AW-1:0] lsu_addr;
  logic          lsu_wen;
  logic [2:0]    lsu_memop;
  logic [DW-1:0] lsu_wdata;
  logic          lsu_resp_valid;
  logic          lsu_resp_err;
  logic [DW-1:0] lsu_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic          mem_wr;
  logic [2:0]    mem_op;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  modport master (
    output ifu_req_valid, ifu_addr, lsu_req_valid, lsu_addr, lsu_wen, lsu_memop, lsu_wdata, mem_rdata,
    input  ifu_req_ready, ifu_resp_valid, ifu_rdata, lsu_req_ready, lsu_resp_valid, lsu_resp_err,
           lsu_rdata, mem_addr, mem_rd, mem_wr, mem_op, mem_wdata
  );
  modport slave (
    input  ifu_req_valid, ifu_addr, lsu_req_valid, lsu_addr, lsu_wen, lsu_memop, lsu_wdata, mem_rdata,
    output ifu_req_ready, ifu_resp_valid, ifu_rdata, lsu_req_ready, lsu_resp_valid, lsu_resp_err,
           lsu_rdata, mem_addr, mem_rd, mem_wr, mem_op, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter_pick.sv
// mem_arb_pick: picks IFU or LSU for the next memory transaction
//   i_ifu_valid/i_lsu_valid: pending requests; i_last: last granted owner (MEM_ARB_RR_EN only)
//   o_grant: one-hot grant indexed by owner (bit 0 IFU, bit 1 LSU)
//   MEM_ARB_RR_EN defined: round-robin on ties; undefined: fixed LSU priority
module mem_arb_pick import mem_port_arbiter_pkg::*; (
  input  logic       i_ifu_valid,
  input  logic       i_lsu_valid,
`ifdef MEM_ARB_RR_EN
  input  logic       i_last,
`endif
  output logic [1:0] o_grant
);
  logic w_lsu;
`ifdef MEM_ARB_RR_EN
  assign w_lsu = (i_ifu_valid && i_lsu_valid) ? (i_last == OWNER_IFU) : i_lsu_valid;
`else
  assign w_lsu = i_lsu_valid;
`endif
  assign o_grant = {w_lsu, i_ifu_valid && !w_lsu};
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one data-memory port between IFU and LSU, one transaction at a time
//   clk, rst_n (async assert, active low); bus: mem_port_arbiter_if.slave (IFU/LSU channels + memory port)
//   LATENCY (1..15): cycles the strobes are held before mem_rdata is sampled
//   MEM_ARB_RR_EN: round-robin arbitration instead of fixed LSU priority
module mem_port_arbiter import mem_port_arbiter_pkg::*; #(
  parameter int LATENCY = 1,
  parameter int AW = 32,
  parameter int DW = 32
)(
  input logic clk,
  input logic rst_n,
  mem_port_arbiter_if.slave bus
);
  state_t        r_state, w_next;
  logic [3:0]    r_cnt;
  logic          r_owner, r_wen, r_err;
  logic [AW-1:0] r_addr;
  logic [2:0]    r_op;
  logic [DW-1:0] r_wdata, r_rdata;
  logic [1:0]    w_grant;
  logic          w_accept, w_lsu, w_mis, w_last_cyc, w_ifu_resp, w_lsu_resp;
  logic [AW-1:0] w_addr;
  logic [2:0]    w_op;
`ifdef MEM_ARB_RR_EN
  logic          r_last;
`endif
  mem_arb_pick u_pick (
    .i_ifu_valid(bus.ifu_req_valid),
    .i_lsu_valid(bus.lsu_req_valid),
`ifdef MEM_ARB_RR_EN
    .i_last(r_last),
`endif
    .o_grant(w_grant)
  );
  always_comb begin
    w_lsu = w_grant[OWNER_LSU];
    w_accept = r_state == ST_IDLE && |w_grant;
    w_addr = w_lsu ? bus.lsu_addr : bus.ifu_addr;
    w_op = w_lsu ? bus.lsu_memop : MEMOP_W;
    w_mis = w_lsu && (((w_op == MEMOP_H || w_op == MEMOP_HU) && w_addr[1:0] == 2'b11) ||
                      (w_op == MEMOP_W && w_addr[1:0] != 2'b00));
    w_last_cyc = r_state == ST_BUSY && r_cnt == 4'd0;
    w_next = r_state == ST_IDLE ? (w_accept ? (w_mis ? ST_RESP : ST_BUSY) : ST_IDLE) :
             r_state == ST_BUSY ? (w_last_cyc ? ST_RESP : ST_BUSY) : ST_IDLE;
    w_ifu_resp = r_state == ST_RESP && r_owner == OWNER_IFU;
    w_lsu_resp = r_state == ST_RESP && r_owner == OWNER_LSU;
    // ready is combinational from valid, so it is forced low while reset is held
    bus.ifu_req_ready = rst_n && w_accept && !w_lsu;
    bus.lsu_req_ready = rst_n && w_accept && w_lsu;
    bus.ifu_resp_valid = w_ifu_resp;
    bus.ifu_rdata = w_ifu_resp ? r_rdata : '0;
    bus.lsu_resp_valid = w_lsu_resp;
    bus.lsu_resp_err = w_lsu_resp && r_err;
    bus.lsu_rdata = w_lsu_resp ? r_rdata : '0;
    bus.mem_rd = r_state == ST_BUSY && !r_wen;
    // the counter only holds LATENCY-1 in the first BUSY cycle, giving one write per store
    bus.mem_wr = r_state == ST_BUSY && r_wen && r_cnt == 4'(LATENCY - 1);
    bus.mem_addr = r_addr;
    bus.mem_op = r_op;
    bus.mem_wdata = r_wdata;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_owner <= OWNER_IFU;
      r_wen <= 1'b0;
      r_err <= 1'b0;
      r_addr <= '0;
      r_op <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else if (w_accept) begin
      r_cnt <= 4'(LATENCY - 1);
      r_owner <= w_lsu;
      r_wen <= w_lsu && bus.lsu_wen;
      r_err <= w_mis;
      r_addr <= w_addr;
      r_op <= w_op;
      r_rdata <= '0;
      if (w_lsu) r_wdata <= bus.lsu_wdata;
    end else if (r_state == ST_BUSY) begin
      if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
      else r_rdata <= r_wen ? '0 : bus.mem_rdata;
    end
  end
`ifdef MEM_ARB_RR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_last <= OWNER_LSU;
    else if (w_accept) r_last <= w_lsu;
  end
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench with a response scoreboard for mem_port_arbiter at LATENCY 1, 3 and 4
//   expectations for the tie test follow MEM_ARB_RR_EN (round-robin) or fixed LSU priority
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;
  typedef struct {
    int          dut;
    logic        owner;
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  always #5 clk = ~clk;
  mem_port_arbiter_if b1 ();
  mem_port_arbiter_if b3 ();
  mem_port_arbiter_if b4 ();
  mem_port_arbiter #(.LATENCY(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  mem_port_arbiter #(.LATENCY(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(b3));
  mem_port_arbiter #(.LATENCY(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(b4));
  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic push(int d, logic o, logic [31:0] r, logic e);
    exp_t x;
    x.dut = d;
    x.owner = o;
    x.rdata = r;
    x.err = e;
    sb.push_back(x);
  endtask
  task automatic mon(int d, logic iv, logic [31:0] ir, logic lv, logic le, logic [31:0] lr);
    exp_t x;
    if (!(iv || lv)) return;
    if (sb.size() == 0) begin
      check($sformatf("unexpected_resp_u%0d", d), {iv, lv}, 2'b00);
      return;
    end
    x = sb.pop_front();
    check("resp_dut", d, x.dut);
    check("resp_owner", {iv, lv}, x.owner ? 2'b01 : 2'b10);
    check("resp_rdata", lv ? lr : ir, x.rdata);
    check("resp_err", le, x.err);
  endtask
  always @(negedge clk) begin
    mon(1, b1.ifu_resp_valid, b1.ifu_rdata, b1.lsu_resp_valid, b1.lsu_resp_err, b1.lsu_rdata);
    mon(3, b3.ifu_resp_valid, b3.ifu_rdata, b3.lsu_resp_valid, b3.lsu_resp_err, b3.lsu_rdata);
    mon(4, b4.ifu_resp_valid, b4.ifu_rdata, b4.lsu_resp_valid, b4.lsu_resp_err, b4.lsu_rdata);
  end
  task automatic mis(string tag, logic [31:0] a, logic [2:0] op, logic wen);
    b3.lsu_req_valid = 1'b1;
    b3.lsu_addr = a;
    b3.lsu_memop = op;
    b3.lsu_wen = wen;
    @(negedge clk);
    check({tag, "_ready"}, b3.lsu_req_ready, 1'b1);
    push(3, OWNER_LSU, 32'h0, 1'b1);
    @(posedge clk);
    #1 b3.lsu_req_valid = 1'b0;
    @(negedge clk);
    check({tag, "_resp"}, {b3.lsu_resp_valid, b3.lsu_resp_err, b3.mem_rd, b3.mem_wr}, 4'b1100);
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic w;
    b1.ifu_req_valid = 1'b1; b1.ifu_addr = 32'h8000_0000;
    b1.lsu_req_valid = 1'b1; b1.lsu_addr = 32'h8000_0010; b1.lsu_wen = 1'b0;
    b1.lsu_memop = MEMOP_W; b1.lsu_wdata = '0; b1.mem_rdata = 32'h0000_0413;
    b3.ifu_req_valid = 1'b0; b3.ifu_addr = '0; b3.lsu_req_valid = 1'b0; b3.lsu_addr = '0;
    b3.lsu_wen = 1'b0; b3.lsu_memop = '0; b3.lsu_wdata = '0; b3.mem_rdata = 32'hCAFE_0001;
    b4.ifu_req_valid = 1'b0; b4.ifu_addr = '0; b4.lsu_req_valid = 1'b0; b4.lsu_addr = '0;
    b4.lsu_wen = 1'b0; b4.lsu_memop = '0; b4.lsu_wdata = '0; b4.mem_rdata = 32'h0BAD_F00D;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ctl_u1", {b1.ifu_req_ready, b1.lsu_req_ready, b1.ifu_resp_valid, b1.lsu_resp_valid,
                         b1.lsu_resp_err, b1.mem_rd, b1.mem_wr}, 7'b0);
    check("rst_data_u1", |{b1.ifu_rdata, b1.lsu_rdata, b1.mem_addr, b1.mem_op, b1.mem_wdata}, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c % 3 == 0) begin
`ifdef MEM_ARB_RR_EN
        w = (c / 3) % 2 == 1;
`else
        w = 1'b1;
`endif
        check("tie_ready", {b1.ifu_req_ready, b1.lsu_req_ready}, w ? 2'b01 : 2'b10);
        push(1, w, 32'h0000_0413, 1'b0);
      end else begin
        check("tie_wait", {b1.ifu_req_ready, b1.lsu_req_ready}, 2'b00);
      end
      @(posedge clk);
      #1;
    end
    b1.ifu_req_valid = 1'b0;
    b1.lsu_req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 b1.ifu_req_valid = 1'b1;
    @(negedge clk);
    check("f_ready", {b1.ifu_req_ready, b1.lsu_req_ready, b1.mem_rd}, 3'b100);
    push(1, OWNER_IFU, 32'h0000_0413, 1'b0);
    @(posedge clk);
    #1 b1.ifu_req_valid = 1'b0;
    @(negedge clk);
    check("f_strobe", {b1.mem_rd, b1.mem_wr, b1.ifu_req_ready}, 3'b100);
    check("f_bus", {b1.mem_op, b1.mem_addr}, {MEMOP_W, 32'h8000_0000});
    @(posedge clk);
    #1;
    @(negedge clk);
    check("f_resp", {b1.ifu_resp_valid, b1.mem_rd}, 2'b10);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("f_resp_once", b1.ifu_resp_valid, 1'b0);
    @(posedge clk);
    #1;
    b3.lsu_req_valid = 1'b1; b3.lsu_addr = 32'h8000_0102; b3.lsu_wen = 1'b1;
    b3.lsu_memop = MEMOP_B; b3.lsu_wdata = 32'h1234_5678;
    @(negedge clk);
    check("st_ready", b3.lsu_req_ready, 1'b1);
    push(3, OWNER_LSU, 32'h0, 1'b0);
    @(posedge clk);
    #1 b3.lsu_req_valid = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      check("st_strobe", {b3.mem_wr, b3.mem_rd}, c == 1 ? 2'b10 : 2'b00);
      check("st_resp", b3.lsu_resp_valid, c == 4);
      if (c == 1) check("st_bus", {b3.mem_addr, b3.mem_wdata}, {32'h8000_0102, 32'h1234_5678});
      if (c == 1) check("st_op", b3.mem_op, MEMOP_B);
      @(posedge clk);
      #1;
    end
    mis("mis_w", 32'h8000_0002, MEMOP_W, 1'b0);
    mis("mis_h", 32'h8000_0003, MEMOP_H, 1'b1);
    b3.lsu_req_valid = 1'b1; b3.lsu_addr = 32'h8000_0002; b3.lsu_memop = MEMOP_H; b3.lsu_wen = 1'b0;
    @(negedge clk);
    check("h_ready", b3.lsu_req_ready, 1'b1);
    push(3, OWNER_LSU, 32'hCAFE_0001, 1'b0);
    @(posedge clk);
    #1 b3.lsu_req_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check("h_rd", b3.mem_rd, c <= 3);
      check("h_resp", b3.lsu_resp_valid, c == 4);
      @(posedge clk);
      #1;
    end
    b4.lsu_req_valid = 1'b1; b4.lsu_addr = 32'h8000_0020; b4.lsu_memop = MEMOP_W; b4.lsu_wen = 1'b0;
    @(negedge clk);
    check("rl_ready", b4.lsu_req_ready, 1'b1);
    @(posedge clk);
    #1 b4.lsu_req_valid = 1'b0;
    @(negedge clk);
    check("rl_rd1", b4.mem_rd, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    b4.ifu_req_valid = 1'b1;
    b4.ifu_addr = 32'h8000_0040;
    #1;
    check("rl_rst_ctl", {b4.ifu_req_ready, b4.lsu_req_ready, b4.ifu_resp_valid, b4.lsu_resp_valid,
                         b4.lsu_resp_err, b4.mem_rd, b4.mem_wr}, 7'b0);
    check("rl_rst_data", |{b4.ifu_rdata, b4.lsu_rdata, b4.mem_addr, b4.mem_op, b4.mem_wdata}, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rl_rst_hold", {b4.ifu_req_ready, b4.mem_rd, b4.mem_wr}, 3'b000);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rl_post_ready", {b4.ifu_req_ready, b4.lsu_req_ready, b4.mem_wr}, 3'b100);
    push(4, OWNER_IFU, 32'h0BAD_F00D, 1'b0);
    @(posedge clk);
    #1 b4.ifu_req_valid = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      check("rl_ifu_rd", {b4.mem_rd, b4.mem_wr}, c <= 4 ? 2'b10 : 2'b00);
      check("rl_ifu_resp", {b4.ifu_resp_valid, b4.lsu_resp_valid}, c == 5 ? 2'b10 : 2'b00);
      @(posedge clk);
      #1;
    end
    check("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
